// File: rtl/pulse_pkg.sv
// Shared definitions for the connector pulse sequencer and its generator:
// FSM encoding, default field width and generator pipeline latency.
package pulse_pkg;

    localparam int DEF_WIDTH   = 25;
    localparam int DEF_GEN_LAT = 4;
    localparam int CNT_W       = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_FIRE  = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4
    } state_t;

endpackage

// File: rtl/pulse_seq_cnt.sv
// Loadable up-counter with synchronous clear and a terminal-compare flag,
// used for both the settle and the pulse-window timers.
module pulse_seq_cnt
    import pulse_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] term_val,
    output logic [CNT_W-1:0] count,
    output logic             at_term
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign at_term = (count == term_val);

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Channel-scan sequencer: for each channel in ch_first..ch_last it settles the
// mux, fires the shared pulse generator once and waits out the pulse window.
module pulse_seq_ctrl
    import pulse_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CH_W    = 4,
    parameter int SETTLE  = 16,
    parameter int GEN_LAT = DEF_GEN_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             loop,
    input  logic [CH_W-1:0]  ch_first,
    input  logic [CH_W-1:0]  ch_last,
    input  logic [WIDTH-1:0] delay_cfg,
    input  logic [WIDTH-1:0] dur_cfg,
    input  logic [WIDTH-1:0] T_cfg,
    output logic             gen_enable,
    output logic [WIDTH-1:0] gen_delay,
    output logic [WIDTH-1:0] gen_duration,
    output logic [WIDTH-1:0] gen_T,
    output logic [CH_W-1:0]  ch_sel,
    output logic             ch_valid,
    output logic             busy,
    output logic             step_done,
    output logic             scan_done,
    output logic             cfg_err,
    output logic [15:0]      scan_cnt,
    output state_t           state_dbg
);

    state_t           state;
    state_t           state_next;
    logic [CH_W-1:0]  ch_first_lat;
    logic [CH_W-1:0]  ch_last_lat;
    logic [WIDTH-1:0] delay_lat;
    logic [WIDTH-1:0] dur_lat;
    logic [WIDTH-1:0] t_lat;
    logic             start_ok;
    logic             more_ch;
    logic             settle_term;
    logic             wait_term;
    logic [CNT_W-1:0] settle_count;
    logic [CNT_W-1:0] wait_count;
    logic [CNT_W-1:0] wait_term_val;

    assign start_ok      = start && (ch_first <= ch_last);
    // Compare before increment, so ch_last at the top of the index range never wraps.
    assign more_ch       = (ch_sel < ch_last_lat);
    assign wait_term_val = CNT_W'(dur_lat) + CNT_W'(GEN_LAT) - CNT_W'(1);

    pulse_seq_cnt u_settle_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (state != S_SETUP),
        .load     (1'b0),
        .en       (state == S_SETUP),
        .load_val ('0),
        .term_val (CNT_W'(SETTLE - 1)),
        .count    (settle_count),
        .at_term  (settle_term)
    );

    pulse_seq_cnt u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (state != S_WAIT),
        .load     (1'b0),
        .en       (state == S_WAIT),
        .load_val ('0),
        .term_val (wait_term_val),
        .count    (wait_count),
        .at_term  (wait_term)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_SETUP;
            S_SETUP: if (abort) state_next = S_IDLE;
                     else if (settle_term) state_next = S_FIRE;
            S_FIRE:  state_next = abort ? S_IDLE : S_WAIT;
            S_WAIT:  if (abort) state_next = S_IDLE;
                     else if (wait_term) state_next = S_NEXT;
            S_NEXT:  if (abort) state_next = S_IDLE;
                     else if (more_ch || loop) state_next = S_SETUP;
                     else state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are gated by abort and reset so neither can leak a late fire or done.
    assign gen_enable   = (state == S_FIRE) && !abort && !reset;
    assign step_done    = (state == S_NEXT) && !abort && !reset;
    assign scan_done    = step_done && !more_ch;
    assign ch_valid     = (state != S_IDLE);
    assign gen_delay    = delay_lat;
    assign gen_duration = dur_lat;
    assign gen_T        = t_lat;
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
            ch_sel       <= '0;
            ch_first_lat <= '0;
            ch_last_lat  <= '0;
            delay_lat    <= '0;
            dur_lat      <= '0;
            t_lat        <= '0;
            scan_cnt     <= '0;
        end else begin
            state   <= state_next;
            busy    <= (state_next != S_IDLE);
            cfg_err <= (state == S_IDLE) && start && (ch_first > ch_last);
            if ((state == S_IDLE) && start_ok) begin
                ch_first_lat <= ch_first;
                ch_last_lat  <= ch_last;
                delay_lat    <= delay_cfg;
                dur_lat      <= dur_cfg;
                t_lat        <= T_cfg;
                ch_sel       <= ch_first;
                scan_cnt     <= '0;
            end else if (step_done) begin
                if (more_ch) begin
                    ch_sel <= ch_sel + CH_W'(1);
                end else begin
                    scan_cnt <= scan_cnt + 16'd1;
                    if (loop) ch_sel <= ch_first_lat;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl: a table of whole-scan vectors plus
// hand-written sequences for loop, abort and reset corner cases.
module tb_pulse_seq_ctrl;
    import pulse_pkg::*;

    localparam int WIDTH   = 25;
    localparam int CH_W    = 4;
    localparam int SETTLE  = 16;
    localparam int GEN_LAT = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic             loop;
    logic [CH_W-1:0]  ch_first;
    logic [CH_W-1:0]  ch_last;
    logic [WIDTH-1:0] delay_cfg;
    logic [WIDTH-1:0] dur_cfg;
    logic [WIDTH-1:0] T_cfg;
    logic             gen_enable;
    logic [WIDTH-1:0] gen_delay;
    logic [WIDTH-1:0] gen_duration;
    logic [WIDTH-1:0] gen_T;
    logic [CH_W-1:0]  ch_sel;
    logic             ch_valid;
    logic             busy;
    logic             step_done;
    logic             scan_done;
    logic             cfg_err;
    logic [15:0]      scan_cnt;
    state_t           state_dbg;

    pulse_seq_ctrl #(
        .WIDTH(WIDTH), .CH_W(CH_W), .SETTLE(SETTLE), .GEN_LAT(GEN_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .loop(loop),
        .ch_first(ch_first), .ch_last(ch_last), .delay_cfg(delay_cfg),
        .dur_cfg(dur_cfg), .T_cfg(T_cfg), .gen_enable(gen_enable),
        .gen_delay(gen_delay), .gen_duration(gen_duration), .gen_T(gen_T),
        .ch_sel(ch_sel), .ch_valid(ch_valid), .busy(busy),
        .step_done(step_done), .scan_done(scan_done), .cfg_err(cfg_err),
        .scan_cnt(scan_cnt), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0]  first;
        logic [CH_W-1:0]  last;
        logic [WIDTH-1:0] delay;
        logic [WIDTH-1:0] dur;
        logic [WIDTH-1:0] t;
        logic             start_abort;
        int               exp_fires;
        int               exp_busy;
        int               exp_scan_done;
        int               exp_cfg_err;
        int               exp_scan_cnt;
        int               exp_ch_end;
        int               exp_gen_delay;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // scoreboard state
    logic [CH_W-1:0]  exp_q[$];
    logic [WIDTH-1:0] exp_delay;
    logic [WIDTH-1:0] exp_dur;
    logic [WIDTH-1:0] exp_t;
    int exp_spacing = 0;
    int cycle       = 0;
    int last_fire   = 0;
    int fire_cnt    = 0;
    int step_cnt    = 0;
    int sdone_cnt   = 0;
    int cerr_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Output monitor: samples 2 time units after each falling edge.
    always @(negedge clk) begin
        #2;
        cycle++;
        if (gen_enable) begin
            fire_cnt++;
            last_fire = cycle;
            if (exp_q.size() == 0) begin
                chk("fire_unexpected", 32'(ch_sel), 32'hFFFF_FFFF);
            end else begin
                chk("fire_ch_sel", 32'(ch_sel), 32'(exp_q.pop_front()));
            end
            chk("fire_gen_delay", 32'(gen_delay), 32'(exp_delay));
            chk("fire_gen_duration", 32'(gen_duration), 32'(exp_dur));
            chk("fire_gen_T", 32'(gen_T), 32'(exp_t));
        end
        if (step_done) begin
            step_cnt++;
            chk("fire_to_step_spacing", 32'(cycle - last_fire), 32'(exp_spacing));
        end
        if (scan_done) sdone_cnt++;
        if (cfg_err) cerr_cnt++;
    end

    // driver tasks
    task automatic reset_counts();
        fire_cnt  = 0;
        step_cnt  = 0;
        sdone_cnt = 0;
        cerr_cnt  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gen_enable"}, 32'(gen_enable), 0);
        chk({tag, "_gen_delay"}, 32'(gen_delay), 0);
        chk({tag, "_gen_duration"}, 32'(gen_duration), 0);
        chk({tag, "_gen_T"}, 32'(gen_T), 0);
        chk({tag, "_ch_sel"}, 32'(ch_sel), 0);
        chk({tag, "_ch_valid"}, 32'(ch_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_step_done"}, 32'(step_done), 0);
        chk({tag, "_scan_done"}, 32'(scan_done), 0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
        chk({tag, "_scan_cnt"}, 32'(scan_cnt), 0);
        chk({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
    endtask

    task automatic set_cfg(input logic [CH_W-1:0] f, input logic [CH_W-1:0] l,
                           input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] du,
                           input logic [WIDTH-1:0] t);
        ch_first  = f;
        ch_last   = l;
        delay_cfg = d;
        dur_cfg   = du;
        T_cfg     = t;
        exp_delay = d;
        exp_dur   = du;
        exp_t     = t;
        exp_spacing = int'(du) + GEN_LAT + 1;
        if (f <= l) begin
            for (int c = int'(f); c <= int'(l); c++) exp_q.push_back(CH_W'(c));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            n++;
            @(negedge clk);
        end
        if (n >= budget) chk({tag, "_idle_timeout"}, 32'(n), 32'(budget - 1));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        string tag;
        tag = $sformatf("vec%0d", idx);
        reset_counts();
        set_cfg(v.first, v.last, v.delay, v.dur, v.t);
        loop  = 1'b0;
        abort = v.start_abort;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        // Scribble over the config inputs; the latched values must hold.
        ch_first  = v.first ^ CH_W'(1);
        ch_last   = v.last ^ CH_W'(3);
        delay_cfg = v.delay + WIDTH'(89);
        dur_cfg   = v.dur + WIDTH'(7);
        T_cfg     = v.t + WIDTH'(3);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            start = (n == 5);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_busy_cycles"}, 32'(n), 32'(v.exp_busy));
        chk({tag, "_fires"}, 32'(fire_cnt), 32'(v.exp_fires));
        chk({tag, "_step_done"}, 32'(step_cnt), 32'(v.exp_fires));
        chk({tag, "_scan_done"}, 32'(sdone_cnt), 32'(v.exp_scan_done));
        chk({tag, "_cfg_err"}, 32'(cerr_cnt), 32'(v.exp_cfg_err));
        chk({tag, "_scan_cnt"}, 32'(scan_cnt), 32'(v.exp_scan_cnt));
        chk({tag, "_ch_sel_end"}, 32'(ch_sel), 32'(v.exp_ch_end));
        chk({tag, "_gen_delay_end"}, 32'(gen_delay), 32'(v.exp_gen_delay));
        chk({tag, "_ch_valid_end"}, 32'(ch_valid), 0);
        chk({tag, "_fires_left"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        int cnt_before;
        vec_t v;

        // Per-channel busy time is SETTLE + 1 + (dur + GEN_LAT) + 1 = dur + 22.
        vecs[0] = '{4'd2,  4'd4,  25'd10, 25'd100, 25'd50, 1'b0, 3, 366, 1, 0, 1, 4,  10};
        vecs[1] = '{4'd5,  4'd3,  25'd77, 25'd5,   25'd9,  1'b0, 0, 0,   0, 1, 1, 4,  10};
        vecs[2] = '{4'd15, 4'd15, 25'd3,  25'd0,   25'd2,  1'b0, 1, 22,  1, 0, 1, 15, 3};
        vecs[3] = '{4'd0,  4'd0,  25'd1,  25'd3,   25'd4,  1'b0, 1, 25,  1, 0, 1, 0,  1};
        vecs[4] = '{4'd7,  4'd9,  25'd20, 25'd7,   25'd30, 1'b1, 3, 87,  1, 0, 1, 9,  20};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        loop  = 1'b0;
        ch_first  = '0;
        ch_last   = '0;
        delay_cfg = '0;
        dur_cfg   = '0;
        T_cfg     = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Loop mode: three scans of channels 0..1, loop dropped during the third.
        reset_counts();
        set_cfg(4'd0, 4'd1, 25'd6, 25'd0, 25'd8);
        set_cfg(4'd0, 4'd1, 25'd6, 25'd0, 25'd8);
        set_cfg(4'd0, 4'd1, 25'd6, 25'd0, 25'd8);
        loop = 1'b1;
        pulse_start();
        n = 0;
        while (sdone_cnt < 2 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("loop_second_scan_seen", 32'(sdone_cnt), 2);
        repeat (10) @(negedge clk);
        loop = 1'b0;
        wait_idle("loop", 1000, n);
        repeat (2) @(negedge clk);
        chk("loop_scan_done", 32'(sdone_cnt), 3);
        chk("loop_scan_cnt", 32'(scan_cnt), 3);
        chk("loop_fires", 32'(fire_cnt), 6);
        chk("loop_state", 32'(state_dbg), 32'(S_IDLE));
        exp_q.delete();

        // Abort ten cycles into the WAIT of channel 1 of a 0..3 scan.
        reset_counts();
        set_cfg(4'd0, 4'd3, 25'd12, 25'd100, 25'd40);
        pulse_start();
        n = 0;
        while (fire_cnt < 2 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("abort_ch1_fired", 32'(fire_cnt), 2);
        repeat (10) @(negedge clk);
        chk("abort_in_wait", 32'(state_dbg), 32'(S_WAIT));
        cnt_before = int'(scan_cnt);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_state", 32'(state_dbg), 32'(S_IDLE));
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ch_valid", 32'(ch_valid), 0);
        repeat (150) @(negedge clk);
        chk("abort_fires", 32'(fire_cnt), 2);
        chk("abort_step_done", 32'(step_cnt), 1);
        chk("abort_scan_done", 32'(sdone_cnt), 0);
        chk("abort_scan_cnt", 32'(scan_cnt), 32'(cnt_before));
        exp_q.delete();
        v = '{4'd1, 4'd2, 25'd5, 25'd2, 25'd9, 1'b0, 2, 48, 1, 0, 1, 2, 5};
        run_vec(v, 5);

        // Abort during the FIRE cycle suppresses the generator strobe.
        reset_counts();
        set_cfg(4'd3, 4'd3, 25'd1, 25'd0, 25'd1);
        exp_q.delete();
        pulse_start();
        n = 0;
        while (state_dbg != S_FIRE && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("fire_abort_reached_fire", 32'(state_dbg), 32'(S_FIRE));
        abort = 1'b1;
        #1;
        chk("fire_abort_gen_enable", 32'(gen_enable), 0);
        @(negedge clk);
        abort = 1'b0;
        chk("fire_abort_state", 32'(state_dbg), 32'(S_IDLE));
        repeat (30) @(negedge clk);
        chk("fire_abort_fires", 32'(fire_cnt), 0);
        chk("fire_abort_steps", 32'(step_cnt), 0);

        // Reset while in SETUP clears every output on the next edge.
        reset_counts();
        set_cfg(4'd2, 4'd5, 25'd10, 25'd50, 25'd60);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("rst_setup_state", 32'(state_dbg), 32'(S_SETUP));
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("rst_setup");
        reset = 1'b0;
        exp_q.delete();
        repeat (40) @(negedge clk);
        chk("rst_setup_no_fire", 32'(fire_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_seq_ctrl.md
Name: pulse_seq_ctrl

Overview:
Sequencer that drives the shared connector pulse generator across a range of connector channels.
- On start, it walks channels ch_first..ch_last. For each channel it:
  - selects the channel and waits a settle time,
  - fires one pulse with the latched timing,
  - waits out the pulse window.
- It sits between the host/config registers and the pulse generator plus the channel multiplexer.
- Optional loop mode repeats scans continuously and counts completed scans.

Parameters:
WIDTH, 25, width of delay/duration/period fields (matches generator).
CH_W, 4, channel index width (up to 16 channels).
SETTLE, 16, cycles the mux is held on a new channel before firing; must be ≥1.
GEN_LAT, 4, extra cycles added to the wait window to cover generator pipeline latency.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a scan; ignored unless IDLE.
abort  in  1  level; terminates a scan in progress.
loop  in  1  1 = restart scan after ch_last until abort; sampled at each scan end.
ch_first  in  CH_W  first channel of scan.
ch_last  in  CH_W  last channel of scan (inclusive).
delay_cfg  in  WIDTH  pulse delay in clocks.
dur_cfg  in  WIDTH  total per-channel window in clocks.
T_cfg  in  WIDTH  pulse end time in clocks.
gen_enable  out  1  one-cycle fire strobe to generator.
gen_delay  out  WIDTH  latched delay to generator.
gen_duration  out  WIDTH  latched duration to generator.
gen_T  out  WIDTH  latched period to generator.
ch_sel  out  CH_W  current channel to mux.
ch_valid  out  1  1 while ch_sel is being driven into a step.
busy  out  1  1 in any state except IDLE.
step_done  out  1  one-cycle pulse at end of each channel window.
scan_done  out  1  one-cycle pulse at normal scan completion.
cfg_err  out  1  one-cycle pulse when start is rejected (ch_first > ch_last).
scan_cnt  out  16  completed scans since last start; wraps at 0xFFFF→0.

Behaviour:
- Reset values:
  - All outputs are 0, ch_sel is 0, and the FSM is IDLE.
  - Reset mid-scan takes effect on the next clock edge with no further strobes.
- Config latch: on an accepted start, ch_first, ch_last, delay_cfg, dur_cfg and T_cfg are latched. gen_* outputs come from the latches and are stable for the whole scan. Input changes during a scan have no effect.
- FSM states: IDLE, SETUP, FIRE, WAIT, NEXT.
  - IDLE:
    - start with ch_first ≤ ch_last → latch config, ch_sel = ch_first, scan_cnt = 0, go to SETUP.
    - start with ch_first > ch_last → cfg_err pulse and stay in IDLE.
  - SETUP: ch_valid = 1; the settle counter counts SETUP cycles. When the count reaches SETUP cycles = SETTLE, go to FIRE.
  - FIRE: gen_enable = 1 for exactly this cycle, then go to WAIT with wait counter = 0.
  - WAIT: count until the counter equals dur_lat + GEN_LAT − 1, then go to NEXT.
    - Window from the FIRE cycle to the NEXT entry = dur_lat + GEN_LAT + 1 cycles.
    - dur_lat = 0 gives GEN_LAT cycles.
  - NEXT:
    - Always pulse step_done.
    - If ch_sel < ch_last_lat: ch_sel++ and go to SETUP.
    - Otherwise: scan_done pulse and scan_cnt++.
      - If loop = 1: ch_sel = ch_first_lat, go to SETUP.
      - If loop = 0: go to IDLE with ch_valid = 0.
- Single-channel scan (ch_first = ch_last) is legal: exactly one fire.
- ch_last = 2^CH_W−1: no index wrap occurs, because the compare precedes the increment.
- Counter width: 32 bits internally; no overflow is possible with WIDTH ≤ 31.
- abort (any non-IDLE state):
  - Next cycle the FSM is IDLE with gen_enable = 0 and ch_valid = 0.
  - No step_done or scan_done is issued.
  - scan_cnt holds its value.
- Priority: abort beats the FIRE strobe in the same cycle (the generator is not fired). reset beats everything.
- start while busy: ignored. start together with abort in IDLE: start wins (abort has no meaning in IDLE).
- busy = (state ≠ IDLE), registered.

Decomposition:
- Shared package pulse_pkg: FSM state encoding constants (S_IDLE..S_NEXT), the default WIDTH, and the GEN_LAT constant shared with the generator.
- One sub-module is natural: pulse_seq_cnt. It is a loadable up-counter with clear and terminal-compare output, instanced for the settle and wait counters.

Test Plan:
- ch_first=2, ch_last=4, SETTLE=16, dur_cfg=100, GEN_LAT=4, loop=0, start → gen_enable pulses exactly 3 times with ch_sel=2,3,4; the FIRE-to-step_done spacing is 105 cycles; one scan_done; scan_cnt=1; busy drops the cycle after NEXT.
- ch_first=5, ch_last=3, start → cfg_err for 1 cycle, busy stays 0, no gen_enable.
- ch_first=ch_last=15, dur_cfg=0 → one fire on ch_sel=15, step_done 5 cycles after FIRE, no wrap to 0.
- loop=1, ch 0..1, deassert loop mid-third scan → scan_done ×3, scan_cnt=3, then IDLE.
- abort asserted 10 cycles into WAIT of channel 1 (range 0..3) → IDLE next cycle, no further step_done/scan_done/gen_enable, scan_cnt unchanged; a fresh start then works normally.
- Change delay_cfg from 10 to 99 mid-scan → gen_delay stays 10 until the next accepted start; reset asserted in SETUP → all outputs 0 on the next cycle.
